// File: rtl/clock_gen_pkg.sv
`default_nettype none
// ============================================================================
// clock_gen_pkg : shared constants and types for clock_gen_multi
// Rev 1.0
// ============================================================================
package clock_gen_pkg;

    localparam int C_DIV_W       = 8;
    localparam int C_DEFAULT_DIV = 1;

    typedef logic [C_DIV_W-1:0] div_t;

    typedef struct packed {
        div_t cnt;
        div_t div_cur;
        div_t div_pend;
        logic pending;
    } ch_state_t;

    // High-time that gives the closest-to-50% duty for a given divisor.
    function automatic int half_up(input int v);
        return (v + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_gen_ch.sv
`default_nettype none
// ============================================================================
// clock_gen_ch : one divider channel (counter, divisor shadow, tick, clk_out)
// Optional macro CLOCK_GEN_DUTY_EN adds a programmable high-time.
// Rev 1.0
// ============================================================================
module clock_gen_ch
    import clock_gen_pkg::*;
#(
    parameter int DIV_W       = C_DIV_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] div_val_i,
`ifdef CLOCK_GEN_DUTY_EN
    input  logic [DIV_W-1:0] hi_val_i,
`endif
    output logic             tick_o,
    output logic             clk_out_o,
    output logic             pending_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
`ifdef CLOCK_GEN_DUTY_EN
    logic [DIV_W-1:0] hi_cur_q, hi_cur_d;
    logic [DIV_W-1:0] hi_pend_q, hi_pend_d;
`endif

    logic             w_tc;
    logic             w_apply;
    logic [DIV_W-1:0] w_cnt_nxt;

    always_comb begin
        w_tc       = (cnt_q == div_cur_q);
        w_cnt_nxt  = w_tc ? '0 : cnt_q + DIV_W'(1);
        // Disabled or at terminal count: a safe moment to swap in a new divisor.
        w_apply    = !enable_i || w_tc;

        cnt_d      = '0;
        tick_d     = 1'b0;
        clk_out_d  = 1'b0;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pending_d  = pending_q;
`ifdef CLOCK_GEN_DUTY_EN
        hi_cur_d   = hi_cur_q;
        hi_pend_d  = hi_pend_q;
`endif

        if (enable_i) begin
            cnt_d  = w_cnt_nxt;
            tick_d = w_tc;
`ifdef CLOCK_GEN_DUTY_EN
            clk_out_d = (w_cnt_nxt < hi_cur_q);
`else
            clk_out_d = w_tc ? ~clk_out_q : clk_out_q;
`endif
        end

        if (w_apply) begin
            pending_d = 1'b0;
            if (wr_i) begin
                div_cur_d = div_val_i;
`ifdef CLOCK_GEN_DUTY_EN
                hi_cur_d  = hi_val_i;
`endif
            end else if (pending_q) begin
                div_cur_d = div_pend_q;
`ifdef CLOCK_GEN_DUTY_EN
                hi_cur_d  = hi_pend_q;
`endif
            end
        end else if (wr_i) begin
            div_pend_d = div_val_i;
            pending_d  = 1'b1;
`ifdef CLOCK_GEN_DUTY_EN
            hi_pend_d  = hi_val_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            pending_q  <= 1'b0;
            div_cur_q  <= DIV_W'(DEFAULT_DIV);
            div_pend_q <= '0;
`ifdef CLOCK_GEN_DUTY_EN
            hi_cur_q   <= DIV_W'(half_up(DEFAULT_DIV));
            hi_pend_q  <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            clk_out_q  <= clk_out_d;
            pending_q  <= pending_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
`ifdef CLOCK_GEN_DUTY_EN
            hi_cur_q   <= hi_cur_d;
            hi_pend_q  <= hi_pend_d;
`endif
        end
    end

    assign tick_o    = tick_q;
    assign clk_out_o = clk_out_q;
    assign pending_o = pending_q;

endmodule
`default_nettype wire

// File: rtl/clock_gen_multi.sv
`default_nettype none
// ============================================================================
// clock_gen_multi : NUM_CH programmable clock-enable / derived-clock channels
// Optional macro CLOCK_GEN_DUTY_EN adds the hi_val duty-cycle input.
// Rev 1.0
// ============================================================================
module clock_gen_multi
    import clock_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = C_DIV_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] enable,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_val,
`ifdef CLOCK_GEN_DUTY_EN
    input  logic [DIV_W-1:0]  hi_val,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] pending
);

    // Channel indices at or beyond NUM_CH match no instance, so such writes drop.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_wr;
        assign w_wr = div_wr && (div_ch == CH_W'(i));

        clock_gen_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable_i  (enable[i]),
            .wr_i      (w_wr),
            .div_val_i (div_val),
`ifdef CLOCK_GEN_DUTY_EN
            .hi_val_i  (hi_val),
`endif
            .tick_o    (tick[i]),
            .clk_out_o (clk_out[i]),
            .pending_o (pending[i])
        );
    end

endmodule
`default_nettype wire

// File: doc/clock_gen_multi.md
Name: clock_gen_multi

Overview:
- Multi-channel programmable clock-enable generator, parametrised in channel count and divider width.
- Each channel divides the system clock by a runtime-programmable ratio, producing:
  - a one-cycle tick pulse;
  - a derived square wave.
- Channels are gated by per-channel enables.
- Divisor updates are glitch-free: while a channel runs, a new ratio takes effect only on a period boundary.
- Feeds timers, UART baud ticks and slow peripheral strobes; replaces the single fixed free-running clock source.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- DIV_W, 8, width of divisor and internal counters.
- DEFAULT_DIV, 1, divisor loaded into every channel on reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  NUM_CH  per-channel run enable.
- div_wr  input  1  divisor write strobe, one cycle.
- div_ch  input  $clog2(NUM_CH) (min 1)  target channel of write.
- div_val  input  DIV_W  divisor; channel period = div_val+1 clk cycles.
- tick  output  NUM_CH  registered one-cycle pulse at end of each period.
- clk_out  output  NUM_CH  registered derived clock.
- pending  output  NUM_CH  1 while a written divisor awaits its period boundary.

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous and active-high, ports named clk and rst.
  - rst has priority over all other inputs, including mid-period.
  - On reset: cnt=0, tick=0, clk_out=0, pending=0, div_cur=DEFAULT_DIV, div_pend=0.
- Per-channel state: cnt, div_cur, div_pend (all DIV_W), pending flag.
- Enabled channel (enable[i]=1) at each edge:
  - If cnt==div_cur: cnt<=0, tick<=1, clk_out<=~clk_out. If pending, div_cur<=div_pend and pending<=0.
  - Else: cnt<=cnt+1, tick<=0.
- Timing:
  - First tick is high during the cycle after the (div_cur+1)th edge at which enable is sampled high.
  - Steady-state tick spacing is div_cur+1 cycles.
  - clk_out period is 2*(div_cur+1) cycles at 50% duty.
  - div_val=0: tick is high every cycle and clk_out toggles every cycle.
  - div_val=2^DIV_W-1: period is 2^DIV_W. The counter never wraps, because it clears at terminal count.
- Disabled channel (enable[i]=0) at each edge:
  - cnt<=0, tick<=0, clk_out<=0.
  - A pending divisor is applied immediately (div_cur<=div_pend, pending<=0).
  - Re-enabling always restarts from phase 0.
- Writes (div_wr=1, div_ch=i):
  - Channel disabled that cycle: div_cur<=div_val directly; pending stays 0.
  - Channel enabled, no terminal count that cycle: div_pend<=div_val, pending<=1.
  - Channel enabled, at terminal count that cycle: div_cur<=div_val directly. A new write wins over an older pending value; pending<=0.
  - Second write before the boundary: overwrites div_pend, which is last-writer-wins.
  - div_ch>=NUM_CH: write ignored.
- Channels are fully independent; there is no phase relationship between channels.

Optional Feature:
- Macro CLOCK_GEN_DUTY_EN.
- Defined:
  - Adds input hi_val (DIV_W), written with the same strobe and pending rules into hi_cur/hi_pend.
  - clk_out is registered as (cnt_next < hi_cur), so the period is div_cur+1 with hi_cur cycles high.
  - hi_cur=0 gives constant low; hi_cur>div_cur gives constant high.
  - Reset value of hi_cur is (DEFAULT_DIV+1)/2.
- Undefined: no hi_val port; clk_out is the toggle mode described above.

Decomposition:
- Package clock_gen_pkg contains:
  - DIV_W default constant;
  - typedef div_t (logic [DIV_W-1:0]);
  - typedef ch_state_t struct (cnt, div_cur, div_pend, pending);
  - DEFAULT_DIV default.
- Sub-module clock_gen_ch implements one channel (counter, divisor shadow, tick and clk_out logic).
- clock_gen_multi decodes div_wr/div_ch into per-channel write strobes and instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset then enable[0]=1, div stays 1 → tick[0] every 2 cycles, clk_out[0] period 4, other channels stay 0.
- Write div_val=3 to ch1 while disabled, then enable → first tick[1] after the 4th enabled edge, spacing 4, clk_out[1] period 8, pending[1] never 1.
- Ch2 running div=5; at cnt=2 write 9, then write 2 before the boundary → pending[2]=1 until the next tick; the following spacing is 3, not 10.
- Write coinciding with terminal count on ch0 (div 1→7) → pending[0] stays 0; next tick 8 cycles later.
- Assert rst at cnt=3 of a div=6 run with pending=1 → all outputs 0 next cycle, div_cur=DEFAULT_DIV, pending dropped.
- Drop enable[3] mid-period, re-raise 5 cycles later → clk_out[3]=0 while off; restart phase 0 with full first period; div_val=0 yields continuous tick.
